debug_trace_buffer: RTL and testbench
=====================================

# debug_trace_buffer

Captures retire-side debug events into a circular trace buffer and drains them oldest-first over a valid/ready port. It sits directly downstream of the debug tap unit and consumes its writeback-stage outputs: WB opcode, PC, destination register, register-write strobe, WB data, and memory-write strobe/data. It gives the bench and an external host a post-mortem history of the last DEPTH architectural writes.

## Interface
- DEPTH, 16, number of entries; power of two, ≥2
- CW, $clog2(DEPTH)+1, width of the count output (derived; not overridden)

Ports:
- clk  in  1  core clock; all state changes on posedge
- reset  in  1  asynchronous, active-high; clears all state
- enable_debug  in  1  arm and keep capture running (level)
- freeze  in  1  stop capture and start drain (level, sampled each cycle)
- opcodeWb  in  7  opcode in the writeback stage
- PC_Dout  in  9  PC tapped by the debug unit
- reg_num_Dout  in  5  destination register
- reg_write_sig_Dout  in  1  register-write strobe
- WB_Data_Dout  in  32  writeback data
- wr_Dout  in  1  data-memory write strobe
- wr_data_Dout  in  32  data-memory write data
- out_valid  out  1  out_entry holds an undrained entry
- out_ready  in  1  consumer accepts entry
- out_entry  out  54  {kind[53], opcode[52:46], pc[45:37], rd[36:32], data[31:0]}
- count  out  CW  entries currently stored
- overflow  out  1  sticky; at least one entry was overwritten during this capture
- busy  out  1  state is CAPTURE or DRAIN

## Operation
- States: IDLE, CAPTURE, DRAIN. Reset state is IDLE.
- IDLE → CAPTURE when enable_debug=1 and freeze=0. Entering CAPTURE clears count, pointers, and overflow.
- CAPTURE: in each cycle with a qualifying event, write one entry at wr_ptr, then wr_ptr++ (mod DEPTH).
  - Register write (reg_write_sig_Dout=1): kind=0, rd=reg_num_Dout, data=WB_Data_Dout.
  - Memory write (wr_Dout=1, reg_write_sig_Dout=0): kind=1, rd=0, data=wr_data_Dout.
  - Both strobes high in the same cycle: the register write is captured and the memory write is dropped.
  - opcode=opcodeWb and pc=PC_Dout in both cases.
  - count<DEPTH: count++.
  - count==DEPTH: overwrite the oldest entry, rd_ptr++, count holds at DEPTH, overflow←1.
- CAPTURE → DRAIN when freeze=1 or enable_debug=0. An event in that same cycle is still captured.
- DRAIN:
  - out_valid = (count≠0).
  - out_entry = mem[rd_ptr], combinational from the register array, stable while out_ready=0.
  - On out_valid & out_ready: rd_ptr++ and count--.
  - No capture happens in DRAIN. enable_debug and freeze are ignored.
- DRAIN → IDLE on the edge where count reaches 0, or immediately if count=0 on entry. overflow stays readable in IDLE until the next CAPTURE entry.
- Outside DRAIN, out_valid=0. out_entry is don't-care when out_valid=0.

## Timing
- Reset values: out_valid=0, count=0, overflow=0, busy=0, state=IDLE, pointers=0. Array contents are not reset.
- Reset asserted mid-operation (CAPTURE or DRAIN) returns to IDLE immediately and asynchronously; all stored entries are lost (count=0).
- An event sampled at edge N is reflected in count after edge N.
- enable_debug rising at edge N gives busy=1 after N. The first capturable event is in the cycle after N.
- freeze high at edge N gives DRAIN after N. out_valid=1 in cycle N+1 if count>0.
- Drain throughput is one entry per cycle with out_ready held high. Latency from pop to next entry is 0 cycles.
- Handshake: out_entry must not change while out_valid=1 and out_ready=0.
- Wrap-around: pointers wrap modulo DEPTH. count is the only full/empty indicator.

## Test plan
- Reset: pulse reset mid-CAPTURE with 5 entries stored → all outputs 0 asynchronously; after release, state is IDLE and count=0.
- Basic trace: enable_debug=1; three register writes (rd=5,6,7; data 0x11,0x22,0x33; PC 0x004,0x008,0x00C); then freeze=1 with out_ready=1 → three entries in that order, count 3→2→1→0, then IDLE and busy=0.
- Overflow: DEPTH=16; 20 register writes with data 1..20; then freeze → drains data 5..20 (16 entries), overflow=1; re-arming clears overflow.
- Mixed strobes: one memory write (wr_data=0xDEADBEEF) → entry with kind=1, rd=0. A cycle with both strobes, WB data 0xA5 and memory data 0xB6 → a single entry with kind=0, data=0xA5.
- Backpressure: in DRAIN, out_ready=0 for 4 cycles → out_valid=1, out_entry and count unchanged; raising out_ready pops one entry per cycle.
- Edge conditions:
  - freeze in the same cycle as an event → that event is the newest entry drained.
  - enable_debug with freeze=1 in IDLE → stays IDLE.
  - freeze with count=0 → DRAIN for one cycle, out_valid=0, then IDLE.

Source files
------------

// File: rtl/debug_trace_buffer.sv
// Circular trace buffer for writeback-stage debug events; captures register and
// memory writes while armed, then drains them oldest-first over valid/ready.
module debug_trace_buffer #(
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable_debug,
    input  logic          freeze,
    input  logic [6:0]    opcodeWb,
    input  logic [8:0]    PC_Dout,
    input  logic [4:0]    reg_num_Dout,
    input  logic          reg_write_sig_Dout,
    input  logic [31:0]   WB_Data_Dout,
    input  logic          wr_Dout,
    input  logic [31:0]   wr_data_Dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [53:0]   out_entry,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          busy
);

    localparam int            PW   = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic [53:0]   mem [DEPTH];

    logic          capture_event;
    logic          pop;
    logic          arm;
    logic [53:0]   new_entry;

    assign capture_event = (state == CAPTURE) && (reg_write_sig_Dout || wr_Dout);
    assign pop           = out_valid && out_ready;
    assign arm           = (state == IDLE) && (state_nxt == CAPTURE);

    // A register write wins over a simultaneous memory write.
    assign new_entry = reg_write_sig_Dout
        ? {1'b0, opcodeWb, PC_Dout, reg_num_Dout, WB_Data_Dout}
        : {1'b1, opcodeWb, PC_Dout, 5'd0, wr_data_Dout};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable_debug && !freeze) state_nxt = CAPTURE;
            CAPTURE: if (freeze || !enable_debug) state_nxt = DRAIN;
            DRAIN:   if ((count_q == '0) || ((count_q == CW'(1)) && pop)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (arm) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (capture_event) begin
            wr_ptr <= wr_ptr + 1'b1;
            // When full the oldest entry is overwritten, so the read side advances too.
            if (count_q == FULL) begin
                rd_ptr     <= rd_ptr + 1'b1;
                overflow_q <= 1'b1;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end else if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            count_q <= count_q - 1'b1;
        end
    end

    // Storage array carries data only and is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (capture_event) mem[wr_ptr] <= new_entry;
    end

    assign out_valid = (state == DRAIN) && (count_q != '0);
    assign out_entry = mem[rd_ptr];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Self-checking bench for debug_trace_buffer: a queue-based reference model
// compared every cycle, plus directed literal checks.
module tb_debug_trace_buffer;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable_debug = 1'b0;
    logic          freeze = 1'b0;
    logic [6:0]    opcodeWb = 7'h33;
    logic [8:0]    PC_Dout = '0;
    logic [4:0]    reg_num_Dout = '0;
    logic          reg_write_sig_Dout = 1'b0;
    logic [31:0]   WB_Data_Dout = '0;
    logic          wr_Dout = 1'b0;
    logic [31:0]   wr_data_Dout = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [53:0]   out_entry;
    logic [CW-1:0] count;
    logic          overflow;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    debug_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .enable_debug(enable_debug), .freeze(freeze),
        .opcodeWb(opcodeWb), .PC_Dout(PC_Dout), .reg_num_Dout(reg_num_Dout),
        .reg_write_sig_Dout(reg_write_sig_Dout), .WB_Data_Dout(WB_Data_Dout),
        .wr_Dout(wr_Dout), .wr_data_Dout(wr_data_Dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_entry(out_entry),
        .count(count), .overflow(overflow), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 capturing, 2 draining; history kept as a queue.
    int          m_mode = 0;
    logic [53:0] m_q[$];
    logic        m_ovf = 1'b0;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_mode = 0;
                m_q.delete();
                m_ovf = 1'b0;
            end else begin
                case (m_mode)
                    0: if (enable_debug && !freeze) begin
                        m_mode = 1;
                        m_q.delete();
                        m_ovf = 1'b0;
                    end
                    1: begin
                        if (reg_write_sig_Dout)
                            m_q.push_back({1'b0, opcodeWb, PC_Dout, reg_num_Dout, WB_Data_Dout});
                        else if (wr_Dout)
                            m_q.push_back({1'b1, opcodeWb, PC_Dout, 5'd0, wr_data_Dout});
                        if (m_q.size() > DEPTH) begin
                            void'(m_q.pop_front());
                            m_ovf = 1'b1;
                        end
                        if (freeze || !enable_debug) m_mode = 2;
                    end
                    default: begin
                        if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
                        if (m_q.size() == 0) m_mode = 0;
                    end
                endcase
            end
        end
    end

    task automatic lit(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            lit("model_busy", {63'd0, busy}, {63'd0, m_mode != 0});
            lit("model_count", {{(64-CW){1'b0}}, count}, 64'(m_q.size()));
            lit("model_overflow", {63'd0, overflow}, {63'd0, m_ovf});
            lit("model_valid", {63'd0, out_valid}, {63'd0, (m_mode == 2) && (m_q.size() != 0)});
            if ((m_mode == 2) && (m_q.size() != 0))
                lit("model_entry", {10'd0, out_entry}, {10'd0, m_q[0]});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ev(input bit rw, input bit mw, input logic [4:0] rd,
                      input logic [31:0] d, input logic [31:0] md, input logic [8:0] pc);
        reg_write_sig_Dout = rw;
        wr_Dout            = mw;
        reg_num_Dout       = rd;
        WB_Data_Dout       = d;
        wr_data_Dout       = md;
        PC_Dout            = pc;
        opcodeWb           = pc[6:0] ^ 7'h33;
        tick();
        reg_write_sig_Dout = 1'b0;
        wr_Dout            = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        out_ready = 1'b1;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        lit("drain_to_idle", {63'd0, busy}, 64'd0);
    endtask

    logic [53:0] held;

    initial begin
        repeat (2) tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        lit("rst_busy", {63'd0, busy}, 64'd0);
        lit("rst_count", {{(64-CW){1'b0}}, count}, 64'd0);
        lit("rst_valid", {63'd0, out_valid}, 64'd0);
        lit("rst_overflow", {63'd0, overflow}, 64'd0);

        // Basic trace of three register writes.
        enable_debug = 1'b1;
        tick();
        ev(1, 0, 5'd5, 32'h11, 0, 9'h004);
        ev(1, 0, 5'd6, 32'h22, 0, 9'h008);
        ev(1, 0, 5'd7, 32'h33, 0, 9'h00C);
        @(negedge clk);
        lit("basic_count3", {{(64-CW){1'b0}}, count}, 64'd3);
        freeze = 1'b1;
        out_ready = 1'b1;
        tick();
        enable_debug = 1'b0;
        freeze = 1'b0;
        @(negedge clk);
        lit("basic_first_data", {32'd0, out_entry[31:0]}, 64'h11);
        lit("basic_first_rd", {59'd0, out_entry[36:32]}, 64'd5);
        lit("basic_first_pc", {55'd0, out_entry[45:37]}, 64'h004);
        tick();
        @(negedge clk);
        lit("basic_second_data", {32'd0, out_entry[31:0]}, 64'h22);
        lit("basic_count2", {{(64-CW){1'b0}}, count}, 64'd2);
        wait_idle();

        // Overflow with 20 writes, then backpressure during drain.
        out_ready = 1'b0;
        enable_debug = 1'b1;
        tick();
        for (int i = 1; i <= 20; i++) ev(1, 0, 5'(i), 32'(i), 0, 9'(i * 4));
        enable_debug = 1'b0;
        tick();
        @(negedge clk);
        lit("ovf_count16", {{(64-CW){1'b0}}, count}, 64'd16);
        lit("ovf_flag", {63'd0, overflow}, 64'd1);
        lit("ovf_oldest_data", {32'd0, out_entry[31:0]}, 64'd5);
        held = out_entry;
        repeat (4) tick();
        @(negedge clk);
        lit("bp_valid", {63'd0, out_valid}, 64'd1);
        lit("bp_entry_stable", {10'd0, out_entry}, {10'd0, held});
        lit("bp_count_stable", {{(64-CW){1'b0}}, count}, 64'd16);
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        lit("bp_next_data", {32'd0, out_entry[31:0]}, 64'd6);
        wait_idle();
        lit("ovf_sticky_idle", {63'd0, overflow}, 64'd1);
        enable_debug = 1'b1;
        tick();
        @(negedge clk);
        lit("rearm_clears_ovf", {63'd0, overflow}, 64'd0);

        // Mixed strobes; freeze arrives with the last event.
        ev(0, 1, 5'd9, 32'h77, 32'hDEADBEEF, 9'h010);
        freeze = 1'b1;
        ev(1, 1, 5'd3, 32'hA5, 32'hB6, 9'h014);
        freeze = 1'b0;
        enable_debug = 1'b0;
        @(negedge clk);
        lit("mixed_count2", {{(64-CW){1'b0}}, count}, 64'd2);
        lit("mem_kind", {63'd0, out_entry[53]}, 64'd1);
        lit("mem_rd_zero", {59'd0, out_entry[36:32]}, 64'd0);
        lit("mem_data", {32'd0, out_entry[31:0]}, 64'hDEADBEEF);
        tick();
        @(negedge clk);
        lit("both_kind", {63'd0, out_entry[53]}, 64'd0);
        lit("both_data", {32'd0, out_entry[31:0]}, 64'hA5);
        lit("both_rd", {59'd0, out_entry[36:32]}, 64'd3);
        wait_idle();

        // Arming with freeze held keeps the buffer idle.
        enable_debug = 1'b1;
        freeze = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        lit("freeze_blocks_arm", {63'd0, busy}, 64'd0);
        freeze = 1'b0;

        // Freeze with nothing captured: one DRAIN cycle then IDLE.
        tick();
        freeze = 1'b1;
        tick();
        @(negedge clk);
        lit("empty_drain_busy", {63'd0, busy}, 64'd1);
        lit("empty_drain_valid", {63'd0, out_valid}, 64'd0);
        tick();
        @(negedge clk);
        lit("empty_drain_idle", {63'd0, busy}, 64'd0);
        freeze = 1'b0;
        enable_debug = 1'b0;
        tick();

        // Asynchronous reset mid-capture with five entries stored.
        enable_debug = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) ev(1, 0, 5'(i + 1), 32'(100 + i), 0, 9'(i));
        #1;
        reset = 1'b1;
        #1;
        lit("async_rst_count", {{(64-CW){1'b0}}, count}, 64'd0);
        lit("async_rst_busy", {63'd0, busy}, 64'd0);
        lit("async_rst_valid", {63'd0, out_valid}, 64'd0);
        enable_debug = 1'b0;
        #10;
        reset = 1'b0;
        @(negedge clk);
        lit("post_rst_idle", {63'd0, busy}, 64'd0);
        lit("post_rst_count", {{(64-CW){1'b0}}, count}, 64'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
